// File: rtl/exe_div_pkg.sv
// Shared definitions for the EXE-stage divider: FSM state encodings and the
// aluop codes the EXE wrapper decodes into div_start / div_signed.
package exe_div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_BUSY = 2'd2,
      DIV_DONE = 2'd3
   } div_state_t;

   localparam logic [7:0] MINIMIPS32_DIV  = 8'h16;
   localparam logic [7:0] MINIMIPS32_DIVU = 8'h17;

endpackage

// File: rtl/exe_div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract
// the divisor, keep the difference or restore, and shift in the quotient bit.
module exe_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] quo_nxt
);

   // The shifted remainder needs WIDTH+1 bits when the divisor is >= 2^(WIDTH-1).
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           borrow;

   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
      borrow  = diff[WIDTH];
      rem_nxt = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], ~borrow};
   end

endmodule

// File: rtl/exe_div.sv
// Multi-cycle restoring divider for issue slot 1 of the EXE stage. Stalls the
// front of the pipe while iterating and holds {HI,LO} until EXE advances.
module exe_div
   import exe_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               div_start,
   input  logic               div_signed,
   input  logic [WIDTH-1:0]   div_opa,
   input  logic [WIDTH-1:0]   div_opb,
   input  logic               div_cancel,
   input  logic               exe_advance,
   output logic               div_stallreq,
   output logic               div_ready,
   output logic [2*WIDTH-1:0] div_result,
   output div_state_t         div_state
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_t       state;
   div_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             q_neg;
   logic             r_neg;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             sa;
   logic             sb;

   function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   exe_div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .quo     (quo),
      .dvs     (dvs),
      .rem_nxt (step_rem),
      .quo_nxt (step_quo)
   );

   assign sa = div_signed & div_opa[WIDTH-1];
   assign sb = div_signed & div_opb[WIDTH-1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= DIV_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (div_cancel) begin
         state_nxt = DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: if (div_start) state_nxt = (div_opb == '0) ? DIV_ZERO : DIV_BUSY;
            DIV_ZERO: state_nxt = DIV_DONE;
            DIV_BUSY: if (cnt == LAST_STEP) state_nxt = DIV_DONE;
            DIV_DONE: if (exe_advance) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
         endcase
      end
   end

   // Operands are magnitudes; signs are reapplied once the last step is done.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt        <= '0;
         rem        <= '0;
         quo        <= '0;
         dvs        <= '0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         div_result <= '0;
      end else if (!div_cancel) begin
         case (state)
            DIV_IDLE: begin
               if (div_start) begin
                  quo   <= neg_if(sa, div_opa);
                  dvs   <= neg_if(sb, div_opb);
                  rem   <= '0;
                  cnt   <= '0;
                  q_neg <= sa ^ sb;
                  r_neg <= sa;
               end
            end
            DIV_BUSY: begin
               rem <= step_rem;
               quo <= step_quo;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_STEP)
                  div_result <= {neg_if(r_neg, step_rem), neg_if(q_neg, step_quo)};
            end
            DIV_ZERO: div_result <= '0;
            default: ;
         endcase
      end
   end

   // Gated by resetn so the stall drops the moment reset is applied.
   assign div_stallreq = resetn & div_start & ~div_cancel & (state != DIV_DONE);
   assign div_ready    = (state == DIV_DONE);
   assign div_state    = state;

endmodule

// File: tb/tb_exe_div.sv
// Self-checking bench for exe_div: directed and random DIV/DIVU operations,
// cancel, hold-in-DONE and asynchronous reset behaviour.
module tb_exe_div;
   import exe_div_pkg::*;

   localparam int W = 32;

   logic           clk;
   logic           resetn;
   logic           div_start;
   logic           div_signed;
   logic [W-1:0]   div_opa;
   logic [W-1:0]   div_opb;
   logic           div_cancel;
   logic           exe_advance;
   logic           div_stallreq;
   logic           div_ready;
   logic [2*W-1:0] div_result;
   div_state_t     div_state;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];

   exe_div #(.WIDTH(W), .CNT_W(6)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .div_start    (div_start),
      .div_signed   (div_signed),
      .div_opa      (div_opa),
      .div_opb      (div_opb),
      .div_cancel   (div_cancel),
      .exe_advance  (exe_advance),
      .div_stallreq (div_stallreq),
      .div_ready    (div_ready),
      .div_result   (div_result),
      .div_state    (div_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Reference: 64-bit arithmetic, C-style truncation toward zero.
   function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Drives one operation; ready is expected to be seen at edge T+exp_lat.
   task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat, input int hold);
      int lat = 0;
      int stall_cnt = 0;
      bit seen = 0;
      logic [63:0] e;
      @(negedge clk);
      div_signed  = sgn;
      div_opa     = a;
      div_opb     = b;
      div_start   = 1'b1;
      exe_advance = (hold == 0);
      exp_q.push_back(exp);
      #1 chk("stall_start", 64'(div_stallreq), 64'd1);
      for (int j = 0; j <= 40; j++) begin
         @(negedge clk);
         div_opa = $urandom;
         div_opb = $urandom;
         if (div_ready) begin
            lat  = j + 1;
            seen = 1;
            break;
         end
         if (div_stallreq) stall_cnt++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      if (!seen) begin
         chk("ready_timeout", 64'd0, 64'd1);
      end else begin
         chk("latency", 64'(lat), 64'(exp_lat));
         chk("stall_cycles", 64'(stall_cnt), 64'(exp_lat - 1));
         chk("result", div_result, e);
         chk("stall_done", 64'(div_stallreq), 64'd0);
         for (int h = 0; h < hold; h++) begin
            chk("hold_ready", 64'(div_ready), 64'd1);
            chk("hold_result", div_result, e);
            chk("hold_stall", 64'(div_stallreq), 64'd0);
            @(negedge clk);
         end
      end
      exe_advance = 1'b1;
      div_start   = 1'b0;
      @(negedge clk);
      chk("idle_ready", 64'(div_ready), 64'd0);
      chk("idle_state", 64'(div_state), 64'(DIV_IDLE));
      exe_advance = 1'b0;
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit rs;
      resetn      = 1'b0;
      div_start   = 1'b0;
      div_signed  = 1'b0;
      div_opa     = '0;
      div_opb     = '0;
      div_cancel  = 1'b0;
      exe_advance = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", 64'(div_state), 64'(DIV_IDLE));
      chk("rst_ready", 64'(div_ready), 64'd0);
      chk("rst_result", div_result, 64'd0);
      div_start = 1'b1;
      #1 chk("rst_stall", 64'(div_stallreq), 64'd0);
      div_start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      run_div(0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
      run_div(1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
      run_div(1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33, 0);
      run_div(1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 0);
      run_div(0, 32'd5, 32'd0, 64'd0, 2, 0);
      run_div(0, 32'hFFFFFFFF, 32'h80000001, {32'h7FFFFFFE, 32'd1}, 33, 0);
      run_div(0, 32'd12345, 32'd100, {32'd45, 32'd123}, 33, 5);

      // Cancel mid-BUSY once the step counter reaches 10.
      @(negedge clk);
      div_signed = 1'b0;
      div_opa    = 32'd1000;
      div_opb    = 32'd3;
      div_start  = 1'b1;
      repeat (11) @(negedge clk);
      chk("cancel_busy", 64'(div_state), 64'(DIV_BUSY));
      div_cancel = 1'b1;
      #1 chk("cancel_stall", 64'(div_stallreq), 64'd0);
      @(negedge clk);
      chk("cancel_state", 64'(div_state), 64'(DIV_IDLE));
      chk("cancel_ready", 64'(div_ready), 64'd0);
      div_cancel = 1'b0;
      div_start  = 1'b0;
      run_div(0, 32'd9, 32'd4, {32'd1, 32'd2}, 33, 0);

      for (int i = 0; i < 8; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : ((i < 3) ? 32'($urandom_range(1, 300)) : $urandom);
         run_div(rs, ra, rb, model(rs, ra, rb), (rb == 0) ? 2 : 33, i % 2);
      end

      // Asynchronous reset in the middle of an operation.
      run_div(0, 32'd77, 32'd5, {32'd2, 32'd15}, 33, 0);
      @(negedge clk);
      div_signed = 1'b0;
      div_opa    = 32'd50;
      div_opb    = 32'd7;
      div_start  = 1'b1;
      repeat (5) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_stall", 64'(div_stallreq), 64'd0);
      chk("arst_ready", 64'(div_ready), 64'd0);
      chk("arst_result", div_result, 64'd0);
      chk("arst_state", 64'(div_state), 64'(DIV_IDLE));
      @(negedge clk);
      div_start = 1'b0;
      resetn    = 1'b1;
      run_div(1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
